stream_fifo: RTL and testbench

//  Parametrised synchronous stb/ack FIFO with a registered output stage. Uses all DEPTH slots, with no wasted slot.

---
 rtl/stream_fifo.sv | 116 +++++++++++
 tb/tb_stream_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// Synchronous stb/ack FIFO with a registered output stage, level, flags and synchronous flush.
// Optional high-water mark output o_hwm when STREAM_FIFO_HWM_EN is defined.
module stream_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_THR  = 12,
  parameter int unsigned AEMPTY_THR = 2,
  localparam int unsigned LW        = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_stb,
  output logic             i_ack,
  output logic [WIDTH-1:0] o_data,
  output logic             o_stb,
  input  logic             o_ack,
  output logic [LW-1:0]    o_level,
`ifdef STREAM_FIFO_HWM_EN
  output logic [LW-1:0]    o_hwm,
`endif
  output logic             o_full,
  output logic             o_empty,
  output logic             o_afull,
  output logic             o_aempty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    ram_cnt;
  logic [LW-1:0]    ram_cnt_d;
  logic [LW-1:0]    level_d;
  logic             push;
  logic             pop;
  logic             load;

  // Full is strict: a pop in the same cycle never frees room for a write.
  assign push  = i_stb & ~o_full & ~i_flush & ~RST;
  assign i_ack = push;
  assign pop   = o_stb & o_ack & ~i_flush;
  assign load  = (ram_cnt != '0) & (~o_stb | o_ack) & ~i_flush;

  always_comb begin
    ram_cnt_d = ram_cnt;
    level_d   = o_level;
    if (i_flush) begin
      ram_cnt_d = '0;
      level_d   = '0;
    end else begin
      ram_cnt_d = ram_cnt + LW'(push) - LW'(load);
      level_d   = o_level + LW'(push) - LW'(pop);
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      o_level  <= '0;
      o_stb    <= 1'b0;
      o_data   <= '0;
      o_full   <= 1'b0;
      o_empty  <= 1'b1;
      o_afull  <= 1'b0;
      o_aempty <= 1'b1;
    end else begin
      ram_cnt  <= ram_cnt_d;
      o_level  <= level_d;
      // Flags track the level register: decoded from its next value.
      o_full   <= (level_d == LW'(DEPTH));
      o_empty  <= (level_d == '0);
      o_afull  <= (level_d >= LW'(AFULL_THR));
      o_aempty <= (level_d <= LW'(AEMPTY_THR));
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        o_stb  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (load) begin
          rd_ptr <= rd_ptr + PW'(1);
          o_data <= mem[rd_ptr];
          o_stb  <= 1'b1;
        end else if (pop) begin
          o_stb  <= 1'b0;
        end
      end
    end
  end

`ifdef STREAM_FIFO_HWM_EN
  // High-water mark follows the registered level one edge later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_hwm <= '0;
    end else if (i_flush) begin
      o_hwm <= '0;
    end else if (o_level > o_hwm) begin
      o_hwm <= o_level;
    end
  end
`else
  // No high-water tracking in this build.
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: directed fill/drain/flush/reset plus seeded random traffic.
// Define STREAM_FIFO_HWM_EN to also check o_hwm.
module tb_stream_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             i_flush = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_stb = 1'b0;
  logic             i_ack;
  logic [WIDTH-1:0] o_data;
  logic             o_stb;
  logic             o_ack = 1'b0;
  logic [LW-1:0]    o_level;
  logic             o_full, o_empty, o_afull, o_aempty;
`ifdef STREAM_FIFO_HWM_EN
  logic [LW-1:0]    o_hwm;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: every word held in the FIFO, head = output register when m_stb.
  logic [WIDTH-1:0] q[$];
  int m_lvl = 0;
  int m_ram = 0;
  bit m_stb = 0;

  stream_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_THR(12), .AEMPTY_THR(2)) dut (
    .CLK(CLK), .RST(RST), .i_flush(i_flush), .i_data(i_data), .i_stb(i_stb), .i_ack(i_ack),
    .o_data(o_data), .o_stb(o_stb), .o_ack(o_ack), .o_level(o_level),
`ifdef STREAM_FIFO_HWM_EN
    .o_hwm(o_hwm),
`endif
    .o_full(o_full), .o_empty(o_empty), .o_afull(o_afull), .o_aempty(o_aempty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compares outputs with the model, then advances the model.
  always @(negedge CLK) begin
    bit exp_ack, pop, load;
    if (RST) begin
      q.delete();
      m_lvl = 0; m_ram = 0; m_stb = 0;
    end else begin
      exp_ack = i_stb && !i_flush && (m_lvl != DEPTH);
      check("i_ack", int'(i_ack), int'(exp_ack));
      check("o_level", int'(o_level), m_lvl);
      check("o_full", int'(o_full), int'(m_lvl == 16));
      check("o_empty", int'(o_empty), int'(m_lvl == 0));
      check("o_afull", int'(o_afull), int'(m_lvl >= 12));
      check("o_aempty", int'(o_aempty), int'(m_lvl <= 2));
      check("o_stb", int'(o_stb), int'(m_stb));
      if (m_stb) begin
        if (q.size() == 0) check("scoreboard_underrun", 1, 0);
        else check("o_data", int'(o_data), int'(q[0]));
      end
      if (i_flush) begin
        q.delete();
        m_lvl = 0; m_ram = 0; m_stb = 0;
      end else begin
        pop  = m_stb && o_ack;
        load = (m_ram > 0) && (!m_stb || o_ack);
        if (exp_ack) q.push_back(i_data);
        if (pop) void'(q.pop_front());
        m_ram = m_ram + int'(exp_ack) - int'(load);
        m_lvl = m_lvl + int'(exp_ack) - int'(pop);
        if (load) m_stb = 1;
        else if (pop) m_stb = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Present one word and hold it until accepted; optional random sink.
  task automatic send(input logic [WIDTH-1:0] d, input bit rnd);
    bit acc = 0;
    i_stb = 1'b1; i_data = d;
    for (int n = 0; n < 200 && !acc; n++) begin
      if (rnd) o_ack = 1'($urandom_range(0, 1));
      @(negedge CLK); acc = i_ack;
      step();
    end
    check("send_timeout", int'(acc), 1);
    i_stb = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    o_ack = 1'b1;
    while ((q.size() != 0 || o_stb) && n < 60) begin step(); n++; end
    check("drain_timeout", int'(n < 60), 1);
    o_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    void'($urandom(32'd1234));
    // Reset state
    step(); step();
    check("rst_o_stb", int'(o_stb), 0);
    check("rst_o_data", int'(o_data), 0);
    check("rst_o_level", int'(o_level), 0);
    check("rst_o_empty", int'(o_empty), 1);
    check("rst_o_aempty", int'(o_aempty), 1);
    check("rst_o_full", int'(o_full), 0);
    check("rst_o_afull", int'(o_afull), 0);
`ifdef STREAM_FIFO_HWM_EN
    check("rst_o_hwm", int'(o_hwm), 0);
`endif
    RST = 1'b0;
    step();

    // Flush / high-water mark
    for (int i = 0; i < 7; i++) send(8'(8'h30 + i), 0);
    check("flush_pre_level", int'(o_level), 7);
    step();
`ifdef STREAM_FIFO_HWM_EN
    check("hwm_before_flush", int'(o_hwm), 7);
`endif
    i_flush = 1'b1; i_stb = 1'b1; i_data = 8'h77; o_ack = 1'b1;
    #1 check("flush_i_ack", int'(i_ack), 0);
    step();
    i_flush = 1'b0; i_stb = 1'b0; o_ack = 1'b0;
    check("flush_level", int'(o_level), 0);
    check("flush_o_stb", int'(o_stb), 0);
`ifdef STREAM_FIFO_HWM_EN
    check("hwm_after_flush", int'(o_hwm), 0);
`endif
    step();

    // Single word latency and hold
    send(8'hA5, 0);
    check("single_stb_k", int'(o_stb), 0);
    step();
    check("single_stb_k1", int'(o_stb), 1);
    check("single_data", int'(o_data), 8'hA5);
    step(); step();
    check("single_hold_stb", int'(o_stb), 1);
    check("single_hold_data", int'(o_data), 8'hA5);
    o_ack = 1'b1; step(); o_ack = 1'b0;
    check("single_popped", int'(o_stb), 0);
    step();

    // Fill to capacity, then a 17th word must stall
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    check("fill_level", int'(o_level), 16);
    check("fill_full", int'(o_full), 1);
    check("fill_afull", int'(o_afull), 1);
    i_stb = 1'b1; i_data = 8'h10;
    for (int i = 0; i < 4; i++) begin
      #1 check("fill_17th_ack", int'(i_ack), 0);
      step();
    end
    i_stb = 1'b0;

    // Drain in order, one per cycle
    drain();
    check("drain_empty", int'(o_empty), 1);
    check("drain_level", int'(o_level), 0);

    // Wrap with random traffic
    for (int i = 0; i < 40; i++) begin
      int idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        o_ack = 1'($urandom_range(0, 1)); step();
      end
      send(8'(i * 7 + 3), 1);
    end
    drain();
    check("wrap_empty", int'(o_empty), 1);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) send(8'(8'hC0 + i), 0);
    i_stb = 1'b1; i_data = 8'hEE;
    #2 RST = 1'b1;
    #1;
    check("arst_o_stb", int'(o_stb), 0);
    check("arst_o_level", int'(o_level), 0);
    check("arst_o_empty", int'(o_empty), 1);
    check("arst_o_aempty", int'(o_aempty), 1);
    check("arst_o_full", int'(o_full), 0);
    check("arst_i_ack", int'(i_ack), 0);
    step();
    RST = 1'b0; i_stb = 1'b0;
    step(); step();
    check("post_rst_level", int'(o_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
